tt_um_seq_divider: RTL and testbench
====================================

TT_UM_SEQ_DIVIDER -- requirements
Module: tt_um_seq_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1 bit: design enable; 0 freezes all registers.
REQ-004 SHALL have port ui_in, input, 8 bits: dividend N[7:0].
REQ-005 SHALL have port uio_in, input, 8 bits:
  - [3:0]: divisor D[3:0]
  - [4]: start
  - [5]: sel
  - [7:6]: ignored
REQ-006 SHALL have port uo_out, output, 8 bits:
  - sel=0: quotient Q[7:0]
  - sel=1: {dz, 3'b000, R[3:0]}
REQ-007 SHALL have port uio_out, output, 8 bits:
  - [6]: busy
  - [7]: done
  - [5:0]: 0
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'b1100_0000.

Function
REQ-009 SHALL use FSM states IDLE, RUN, DONE; start_q register holds previous start sample for edge detection.
REQ-010 SHALL detect a start event at edge k when start=1, start_q=0, ena=1.
REQ-011 SHALL accept a start event only in IDLE or DONE; on acceptance at edge k:
  - latch N and D
  - clear done
  - D!=0: enter RUN, iteration count=0
REQ-012 SHALL ignore start events in RUN (no relatch, no restart).
REQ-013 SHALL, in RUN, perform one restoring-division step per edge, 8 steps total, MSB of N first:
  - 5-bit partial remainder P = {P[3:0], next N bit}
  - if P >= D: P = P - D and quotient bit = 1; else quotient bit = 0
REQ-014 SHALL enter DONE at edge k+8 and load Q and R from the final step; dz=0.
REQ-015 SHALL hold busy=1 exactly while in RUN: after edge k through before edge k+8, 8 cycles.
REQ-016 SHALL hold done=1 while in DONE, until the next accepted start.
REQ-017 SHALL hold the result registers Q, R, dz at prior values throughout RUN; updated only on entering DONE.
REQ-018 SHALL, on accepted start with D=0:
  - enter DONE directly at edge k; never enter RUN; busy stays 0
  - Q=8'hFF, R=4'hF, dz=1
REQ-019 SHALL hold all registers when ena=0, including FSM, counter, start_q and results; outputs stay stable.
REQ-020 SHALL make sel purely combinational on uo_out, with no effect on state.
REQ-021 SHALL guarantee Q*D+R == N and R < D for every D!=0 and all 8-bit N.

Reset
REQ-022 SHALL, while rst_n=0, immediately force:
  - state=IDLE, start_q=0, counter=0
  - Q=0, R=0, dz=0
  - busy=0, done=0, uo_out=0
REQ-023 SHALL abort an in-progress RUN on reset mid-operation and produce no result.
REQ-024 SHALL require a fresh 0->1 start after rst_n release; start held high through reset release is not a start event.

Verification
REQ-025 SHALL check normal division: N=200, D=7, pulse start.
  - busy for 8 cycles, done at k+8
  - Q=28 (0x1C); sel=1 gives 0x04
REQ-026 SHALL check boundaries:
  - N=255, D=1 -> Q=0xFF, R=0, dz=0
  - N=0, D=9 -> Q=0, R=0
  - N=100, D=13 -> Q=7, R=9
REQ-027 SHALL check divide-by-zero: N=15, D=0.
  - done one edge after start, busy never 1
  - Q=0xFF; sel=1 gives 0x8F
REQ-028 SHALL check start held high for 20 cycles with N=200, D=7, then changing N/D mid-RUN.
  - exactly one operation, result Q=28, R=4
  - second start pulse while busy is ignored
REQ-029 SHALL check rst_n low at RUN step 4, then released.
  - all outputs 0 immediately
  - new start N=50, D=6 -> Q=8, R=2
REQ-030 SHALL check ena=0 for 5 cycles mid-RUN.
  - busy/done latency stretched by exactly 5 cycles
  - result unchanged and correct

Source files
------------

// File: rtl/tt_um_seq_divider.sv
// Sequential 8-bit / 4-bit restoring divider: one quotient bit per enabled clock,
// with a direct divide-by-zero path and a sel-muxed result port.
module tt_um_seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic       start, sel;
  logic [3:0] d_in;
  logic       start_q, armed;
  logic [2:0] cnt;
  logic [7:0] n_sh, q_sh, q_r;
  logic [3:0] d_r, p_r, r_r;
  logic       dz_r;
  logic       start_evt, accept;
  logic [4:0] p_ext, p_sub;
  logic       q_bit;
  logic [3:0] p_nxt;
  logic       unused;

  assign d_in   = uio_in[3:0];
  assign start  = uio_in[4];
  assign sel    = uio_in[5];
  assign unused = &{1'b0, uio_in[7:6]};

  // armed blocks a start level that was already high when reset released
  assign start_evt = ena & start & ~start_q & armed;
  assign accept    = start_evt & (state != RUN);

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    p_ext = {p_r, n_sh[7]};
    p_sub = p_ext - {1'b0, d_r};
    q_bit = (p_ext >= {1'b0, d_r});
    p_nxt = q_bit ? p_sub[3:0] : p_ext[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE, DONE: if (accept) state_nxt = (d_in == 4'd0) ? DONE : RUN;
        RUN:        if (cnt == 3'd7) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      armed   <= 1'b0;
      cnt     <= 3'd0;
      n_sh    <= 8'd0;
      q_sh    <= 8'd0;
      d_r     <= 4'd0;
      p_r     <= 4'd0;
      q_r     <= 8'd0;
      r_r     <= 4'd0;
      dz_r    <= 1'b0;
    end else if (ena) begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      if (accept) begin
        n_sh <= ui_in;
        d_r  <= d_in;
        p_r  <= 4'd0;
        q_sh <= 8'd0;
        cnt  <= 3'd0;
        if (d_in == 4'd0) begin
          q_r  <= 8'hFF;
          r_r  <= 4'hF;
          dz_r <= 1'b1;
        end
      end else if (state == RUN) begin
        n_sh <= {n_sh[6:0], 1'b0};
        q_sh <= {q_sh[6:0], q_bit};
        p_r  <= p_nxt;
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          q_r  <= {q_sh[6:0], q_bit};
          r_r  <= p_nxt;
          dz_r <= 1'b0;
        end
      end
    end
  end

  assign uo_out  = sel ? {dz_r, 3'b000, r_r} : q_r;
  assign uio_out = {state == DONE, state == RUN, 6'b000000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Self-checking bench for tt_um_seq_divider: directed scenarios plus random
// operands scored against plain integer division.
module tb_tt_um_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  tt_um_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Launch one operation and wait (bounded) for done; returns both result views.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                        output logic [7:0] q, output logic [7:0] hi,
                        output int lat, output int busy_cyc);
    uio_in = 8'h00;
    step();
    ui_in  = n;
    uio_in = {3'b000, 1'b1, d};
    step();
    uio_in = {3'b000, 1'b0, d};
    lat = 0; busy_cyc = 0;
    while (!uio_out[7] && lat < 40) begin
      if (uio_out[6]) busy_cyc++;
      step();
      lat++;
    end
    q = uo_out;
    uio_in[5] = 1'b1; #1;
    hi = uo_out;
    uio_in[5] = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h20;
    #3;
    n_checks++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out got=%h exp=00", uo_out); end
    n_checks++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
    n_checks++; if (uio_oe !== 8'hC0) begin n_fail++; $display("FAIL reset_uio_oe got=%h exp=c0", uio_oe); end
    uio_in = 8'h00;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=00", uio_out); end
  endtask

  task automatic test_basic();
    logic [7:0] q, hi;
    int lat, bc;
    run_op(8'd200, 4'd7, q, hi, lat, bc);
    n_checks++; if (q !== 8'h1C) begin n_fail++; $display("FAIL basic_q got=%h exp=1c", q); end
    n_checks++; if (hi !== 8'h04) begin n_fail++; $display("FAIL basic_hi got=%h exp=04", hi); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    // results must hold the previous answer while a new division runs
    ui_in = 8'd100; uio_in = {3'b000, 1'b1, 4'd13};
    step();
    uio_in = 8'h0D;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (uo_out !== 8'h1C || uio_out !== 8'h40) begin
        n_fail++; $display("FAIL hold_during_run cyc=%0d uo=%h uio=%h exp uo=1c uio=40", i, uo_out, uio_out);
      end
      step();
    end
    n_checks++; if (uo_out !== 8'h07 || uio_out !== 8'h80) begin
      n_fail++; $display("FAIL second_op uo=%h uio=%h exp uo=07 uio=80", uo_out, uio_out);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] tn [3] = '{8'd255, 8'd0, 8'd100};
    logic [3:0] td [3] = '{4'd1, 4'd9, 4'd13};
    logic [7:0] tq [3] = '{8'hFF, 8'h00, 8'h07};
    logic [7:0] th [3] = '{8'h00, 8'h00, 8'h09};
    logic [7:0] q, hi;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(tn[i], td[i], q, hi, lat, bc);
      n_checks++; if (q !== tq[i] || hi !== th[i] || lat !== 8) begin
        n_fail++; $display("FAIL boundary n=%0d d=%0d q=%h hi=%h lat=%0d exp q=%h hi=%h lat=8",
                           tn[i], td[i], q, hi, lat, tq[i], th[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, hi;
    int lat, bc;
    run_op(8'd15, 4'd0, q, hi, lat, bc);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL dz_latency got=%0d exp=0", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL dz_busy got=%0d exp=0", bc); end
    n_checks++; if (q !== 8'hFF) begin n_fail++; $display("FAIL dz_q got=%h exp=ff", q); end
    n_checks++; if (hi !== 8'h8F) begin n_fail++; $display("FAIL dz_hi got=%h exp=8f", hi); end
  endtask

  task automatic test_start_held();
    int busy_cnt, done_at;
    uio_in = 8'h00;
    step();
    ui_in = 8'd200; uio_in = {3'b000, 1'b1, 4'd7};
    step();
    busy_cnt = uio_out[6] ? 1 : 0;
    done_at = -1;
    for (int i = 1; i < 20; i++) begin
      if (i == 3) begin ui_in = 8'd55; uio_in = {3'b000, 1'b1, 4'd3}; end
      step();
      if (uio_out[6]) busy_cnt++;
      if (uio_out[7] && done_at < 0) done_at = i;
    end
    n_checks++; if (busy_cnt !== 8) begin n_fail++; $display("FAIL held_busy got=%0d exp=8", busy_cnt); end
    n_checks++; if (done_at !== 8) begin n_fail++; $display("FAIL held_done_at got=%0d exp=8", done_at); end
    n_checks++; if (uio_out !== 8'h80) begin n_fail++; $display("FAIL held_no_restart got=%h exp=80", uio_out); end
    uio_in = 8'h00; step();
    n_checks++; if (uo_out !== 8'h1C) begin n_fail++; $display("FAIL held_q got=%h exp=1c", uo_out); end
    uio_in = 8'h20; #1;
    n_checks++; if (uo_out !== 8'h04) begin n_fail++; $display("FAIL held_hi got=%h exp=04", uo_out); end
    // second pulse while busy must be ignored
    ui_in = 8'd200; uio_in = {3'b000, 1'b1, 4'd7};
    step();
    uio_in = 8'h07; step(); step();
    ui_in = 8'd55; uio_in = {3'b000, 1'b1, 4'd3};
    step();
    uio_in = 8'h03;
    done_at = 3;
    while (!uio_out[7] && done_at < 40) begin step(); done_at++; end
    n_checks++; if (done_at !== 8) begin n_fail++; $display("FAIL repulse_latency got=%0d exp=8", done_at); end
    n_checks++; if (uo_out !== 8'h1C) begin n_fail++; $display("FAIL repulse_q got=%h exp=1c", uo_out); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, hi;
    int lat, bc;
    uio_in = 8'h00; step();
    ui_in = 8'd200; uio_in = {3'b000, 1'b1, 4'd7};
    step();
    uio_in = 8'h07;
    repeat (4) step();
    rst_n = 1'b0; #1;
    n_checks++; if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs uo=%h uio=%h exp 00 00", uo_out, uio_out);
    end
    uio_in = 8'h37; #1;
    n_checks++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midreset_sel1 got=%h exp=00", uo_out); end
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL held_start_after_reset got=%h exp=00", uio_out); end
    run_op(8'd50, 4'd6, q, hi, lat, bc);
    n_checks++; if (q !== 8'd8 || hi !== 8'h02 || lat !== 8) begin
      n_fail++; $display("FAIL post_reset_op q=%h hi=%h lat=%0d exp q=08 hi=02 lat=8", q, hi, lat);
    end
  endtask

  task automatic test_ena_stall();
    logic [7:0] prev;
    int lat;
    uio_in = 8'h00; step();
    prev = uo_out;
    ui_in = 8'd200; uio_in = {3'b000, 1'b1, 4'd7};
    step();
    uio_in = 8'h07;
    repeat (3) step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) uio_in = 8'h17;
      step();
      n_checks++; if (uio_out !== 8'h40 || uo_out !== prev) begin
        n_fail++; $display("FAIL ena_freeze cyc=%0d uio=%h uo=%h exp uio=40 uo=%h", i, uio_out, uo_out, prev);
      end
    end
    uio_in = 8'h07;
    ena = 1'b1;
    lat = 8;
    while (!uio_out[7] && lat < 40) begin step(); lat++; end
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL ena_latency got=%0d exp=13", lat); end
    n_checks++; if (uo_out !== 8'h1C) begin n_fail++; $display("FAIL ena_q got=%h exp=1c", uo_out); end
  endtask

  task automatic test_random();
    logic [7:0] n, q, hi, eq, eh;
    logic [3:0] d;
    int lat, bc, el;
    for (int i = 0; i < 40; i++) begin
      n = 8'($urandom_range(0, 255));
      d = 4'($urandom_range(0, 15));
      if (d == 4'd0) begin
        eq = 8'hFF; eh = 8'h8F; el = 0;
      end else begin
        eq = 8'(int'(n) / int'(d));
        eh = 8'(int'(n) % int'(d));
        el = 8;
      end
      run_op(n, d, q, hi, lat, bc);
      n_checks++; if (q !== eq || hi !== eh || lat !== el) begin
        n_fail++; $display("FAIL random n=%0d d=%0d q=%h hi=%h lat=%0d exp q=%h hi=%h lat=%0d",
                           n, d, q, hi, lat, eq, eh, el);
      end
      if (d != 4'd0) begin
        n_checks++; if (int'(q) * int'(d) + int'(hi[3:0]) != int'(n) || hi[3:0] >= d) begin
          n_fail++; $display("FAIL identity n=%0d d=%0d q=%0d r=%0d", n, d, q, hi[3:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_start_held();
    test_reset_mid();
    test_ena_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
